// File: rtl/mips_mc_control_if.sv
// ============================================================================
//  Module   : mips_mc_control_if
//  Purpose  : Controller <-> datapath/memory signal bundle for mips_mc_control.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_mc_control_if;
  logic [31:0] imem_rdata;
  logic        imem_busy;
  logic        dmem_busy;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [2:0]  state;
  logic        opnd_en;
  logic        dmem_en;
  logic        dmem_rd_wr;
  logic [1:0]  dmem_size;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_num;
  logic [1:0]  wb_sel;
  logic        retire;
  logic        illegal;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  modport master (
    input  imem_rdata, imem_busy, dmem_busy, rs_data, rt_data,
    output pc, ir, state, opnd_en, dmem_en, dmem_rd_wr, dmem_size,
           reg_wr_en, reg_wr_num, wb_sel, retire, illegal,
           cycle_count, instr_count
  );

  modport slave (
    output imem_rdata, imem_busy, dmem_busy, rs_data, rt_data,
    input  pc, ir, state, opnd_en, dmem_en, dmem_rd_wr, dmem_size,
           reg_wr_en, reg_wr_num, wb_sel, retire, illegal,
           cycle_count, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/mips_mc_control.sv
// ============================================================================
//  Module   : mips_mc_control
//  Purpose  : Multi-cycle MIPS sequencer with memory stalls and variable CPI.
//             Define MIPS_MC_PERF_EN to build the cycle/instruction counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_mc_control #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter bit          SKIP_MEM = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mips_mc_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_npc;
  logic [31:0] w_npc, w_pc4, w_br_tgt;
  logic [5:0]  w_op, w_func;

  logic w_rtype, w_jr, w_j, w_jal, w_beq, w_bne, w_addiu, w_slti, w_mul;
  logic w_lw, w_lbu, w_sw, w_sb;
  logic w_load, w_store, w_mem, w_alu, w_writer, w_legal, w_ctl, w_taken;
  logic w_to_fetch;

  assign w_op    = r_ir[31:26];
  assign w_func  = r_ir[5:0];
  assign w_rtype = (w_op == 6'b000000);
  assign w_jr    = w_rtype && (w_func == 6'b001000);
  assign w_j     = (w_op == 6'b000010);
  assign w_jal   = (w_op == 6'b000011);
  assign w_beq   = (w_op == 6'b000100);
  assign w_bne   = (w_op == 6'b000101);
  assign w_addiu = (w_op == 6'b001001);
  assign w_slti  = (w_op == 6'b001010);
  assign w_mul   = (w_op == 6'b011100);
  assign w_lw    = (w_op == 6'b100011);
  assign w_lbu   = (w_op == 6'b100100);
  assign w_sw    = (w_op == 6'b101011);
  assign w_sb    = (w_op == 6'b101000);

  assign w_load   = w_lw | w_lbu;
  assign w_store  = w_sw | w_sb;
  assign w_mem    = w_load | w_store;
  assign w_alu    = (w_rtype & ~w_jr) | w_addiu | w_slti | w_mul;
  assign w_writer = w_alu | w_load | w_jal;
  assign w_legal  = w_rtype | w_j | w_jal | w_beq | w_bne | w_addiu | w_slti |
                    w_mul | w_mem;
  assign w_ctl    = w_beq | w_bne | w_j | w_jr | ~w_legal;
  assign w_taken  = (w_beq && (bus.rs_data == bus.rt_data)) ||
                    (w_bne && (bus.rs_data != bus.rt_data));

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_tgt = w_pc4 + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  always_comb begin
    w_npc = w_pc4;
    if (w_taken)
      w_npc = w_br_tgt;
    else if (w_j || w_jal)
      w_npc = {r_pc[31:28], r_ir[25:0], 2'b00};
    else if (w_jr)
      w_npc = bus.rs_data;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:  if (!bus.imem_busy) w_next = DECODE;
      DECODE: w_next = EXEC;
      EXEC: begin
        if (!SKIP_MEM)   w_next = MEM;
        else if (w_ctl)  w_next = FETCH;
        else if (w_mem)  w_next = MEM;
        else             w_next = WB;
      end
      MEM: begin
        if (!(w_mem && bus.dmem_busy))
          w_next = (SKIP_MEM && w_store) ? FETCH : WB;
      end
      WB:      w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  assign w_to_fetch = (r_state != FETCH) && (w_next == FETCH);

  // Target is resolved in EXEC; later states replay the copy held in r_npc.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= PC_INIT;
      r_ir    <= 32'd0;
      r_npc   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && !bus.imem_busy) r_ir <= bus.imem_rdata;
      if (r_state == EXEC) r_npc <= w_npc;
      if (w_to_fetch) r_pc <= (r_state == EXEC) ? w_npc : r_npc;
    end
  end

  assign bus.pc         = r_pc;
  assign bus.ir         = r_ir;
  assign bus.state      = r_state;
  assign bus.opnd_en    = ~reset && (r_state == DECODE);
  assign bus.dmem_en    = ~reset && (r_state == MEM) && w_mem;
  assign bus.dmem_rd_wr = reset || !((r_state == MEM) && w_store);
  assign bus.dmem_size  = (w_lbu || w_sb) ? 2'b00 : 2'b01;
  assign bus.reg_wr_en  = ~reset && (r_state == WB) && w_writer;
  assign bus.reg_wr_num = w_jal ? 5'd31 :
                          (w_addiu || w_slti || w_load) ? r_ir[20:16] : r_ir[15:11];
  assign bus.wb_sel     = w_load ? 2'd1 : (w_jal ? 2'd2 : 2'd0);
  assign bus.retire     = ~reset && w_to_fetch;
  assign bus.illegal    = ~reset && (r_state == EXEC) && ~w_legal;

`ifdef MIPS_MC_PERF_EN
  logic [31:0] r_cycle_count, r_instr_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= 32'd0;
      r_instr_count <= 32'd0;
    end else begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (w_to_fetch) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign bus.cycle_count = r_cycle_count;
  assign bus.instr_count = r_instr_count;
`else
  assign bus.cycle_count = 32'd0;
  assign bus.instr_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_control.sv
// ============================================================================
//  Module   : tb_mips_mc_control
//  Purpose  : Scoreboard bench for mips_mc_control (SKIP_MEM=1 and SKIP_MEM=0).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic [31:0] t_imem, t_rs, t_rt;
  logic        t_ibusy, t_dbusy;

  mips_mc_control_if ifa ();
  mips_mc_control_if ifb ();

  assign ifa.imem_rdata = t_imem;
  assign ifa.imem_busy  = t_ibusy;
  assign ifa.dmem_busy  = t_dbusy;
  assign ifa.rs_data    = t_rs;
  assign ifa.rt_data    = t_rt;
  assign ifb.imem_rdata = t_imem;
  assign ifb.imem_busy  = t_ibusy;
  assign ifb.dmem_busy  = t_dbusy;
  assign ifb.rs_data    = t_rs;
  assign ifb.rt_data    = t_rt;

  mips_mc_control #(.PC_INIT(32'h0000_0100), .SKIP_MEM(1'b1)) u_dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.master));
  mips_mc_control #(.PC_INIT(32'h0000_0000), .SKIP_MEM(1'b0)) u_dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.master));

  // Observed view follows whichever controller is under test.
  logic        w_reset, w_opnd, w_den, w_drw, w_wen, w_retire, w_ill;
  logic [31:0] w_pc, w_ir, w_cyc, w_ins;
  logic [2:0]  w_state;
  logic [1:0]  w_dsize, w_wsel;
  logic [4:0]  w_wnum;
  assign w_reset  = sel ? rst_b : rst_a;
  assign w_pc     = sel ? ifb.pc : ifa.pc;
  assign w_ir     = sel ? ifb.ir : ifa.ir;
  assign w_state  = sel ? ifb.state : ifa.state;
  assign w_opnd   = sel ? ifb.opnd_en : ifa.opnd_en;
  assign w_den    = sel ? ifb.dmem_en : ifa.dmem_en;
  assign w_drw    = sel ? ifb.dmem_rd_wr : ifa.dmem_rd_wr;
  assign w_dsize  = sel ? ifb.dmem_size : ifa.dmem_size;
  assign w_wen    = sel ? ifb.reg_wr_en : ifa.reg_wr_en;
  assign w_wnum   = sel ? ifb.reg_wr_num : ifa.reg_wr_num;
  assign w_wsel   = sel ? ifb.wb_sel : ifa.wb_sel;
  assign w_retire = sel ? ifb.retire : ifa.retire;
  assign w_ill    = sel ? ifb.illegal : ifa.illegal;
  assign w_cyc    = sel ? ifb.cycle_count : ifa.cycle_count;
  assign w_ins    = sel ? ifb.instr_count : ifa.instr_count;

  typedef struct {
    int          cyc;
    int          wr;
    logic [4:0]  wnum;
    logic [1:0]  wsel;
    int          dcyc;
    int          wcyc;
    int          ill;
    logic [1:0]  dsize;
    logic [31:0] npc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input int cyc, input int wr, input logic [4:0] wnum,
                              input logic [1:0] wsel, input int dcyc, input int wcyc,
                              input int ill, input logic [1:0] dsize,
                              input logic [31:0] npc);
    exp_t e;
    e.cyc = cyc; e.wr = wr; e.wnum = wnum; e.wsel = wsel; e.dcyc = dcyc;
    e.wcyc = wcyc; e.ill = ill; e.dsize = dsize; e.npc = npc;
    return e;
  endfunction

  // Monitor: accumulates per-instruction observations, scores on retire.
  initial begin
    exp_t        e;
    int          o_cyc, o_wr, o_dcyc, o_wcyc, o_ill, o_opn;
    logic [4:0]  o_wnum;
    logic [1:0]  o_wsel, o_dsize;
    logic        pend;
    logic [31:0] pend_pc;
    o_cyc = 0; o_wr = 0; o_dcyc = 0; o_wcyc = 0; o_ill = 0; o_opn = 0;
    o_wnum = '0; o_wsel = '0; o_dsize = '0; pend = 1'b0; pend_pc = '0;
    forever begin
      @(negedge clk);
      if (w_reset) begin
        o_cyc = 0; o_wr = 0; o_dcyc = 0; o_wcyc = 0; o_ill = 0; o_opn = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("pc_after_retire", w_pc, pend_pc);
          check("state_after_retire", {29'd0, w_state}, 32'd0);
          pend = 1'b0;
        end
        o_cyc++;
        if (w_opnd) o_opn++;
        if (w_den) begin
          o_dcyc++;
          o_dsize = w_dsize;
          if (!w_drw) o_wcyc++;
        end
        if (w_wen) begin
          o_wr++;
          o_wnum = w_wnum;
          o_wsel = w_wsel;
        end
        if (w_ill) o_ill++;
        if (w_retire) begin
          if (q.size() == 0) begin
            check("retire_with_empty_queue", q.size(), 1);
          end else begin
            e = q.pop_front();
            check("cpi", o_cyc, e.cyc);
            check("opnd_en_cycles", o_opn, 1);
            check("reg_wr_en_cycles", o_wr, e.wr);
            if (e.wr != 0) begin
              check("reg_wr_num", {27'd0, o_wnum}, {27'd0, e.wnum});
              check("wb_sel", {30'd0, o_wsel}, {30'd0, e.wsel});
            end
            check("dmem_en_cycles", o_dcyc, e.dcyc);
            check("dmem_write_cycles", o_wcyc, e.wcyc);
            if (e.dcyc != 0) check("dmem_size", {30'd0, o_dsize}, {30'd0, e.dsize});
            check("illegal_pulses", o_ill, e.ill);
            pend    = 1'b1;
            pend_pc = e.npc;
          end
          o_cyc = 0; o_wr = 0; o_dcyc = 0; o_wcyc = 0; o_ill = 0; o_opn = 0;
        end
      end
    end
  end

  // Entered at posedge+1 with the DUT in FETCH; returns the same way.
  task automatic run(input logic [31:0] instr, input logic [31:0] rs,
                     input logic [31:0] rt, input int ib, input int db,
                     input exp_t e);
    int   dleft;
    logic done;
    q.push_back(e);
    t_imem = instr; t_rs = rs; t_rt = rt;
    dleft = db;
    done  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      t_ibusy = (k <= ib);
      t_dbusy = w_den && (dleft > 0);
      if (t_dbusy) dleft--;
      @(negedge clk);
      done = w_retire;
      @(posedge clk);
      #1;
      if (done) break;
    end
    check("retire_within_budget", {31'd0, done}, 32'd1);
    t_ibusy = 1'b0;
    t_dbusy = 1'b0;
  endtask

  initial begin
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    t_imem = '0; t_rs = '0; t_rt = '0; t_ibusy = 1'b0; t_dbusy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", w_pc, 32'h100);
    check("reset_state", {29'd0, w_state}, 32'd0);
    check("reset_ir", w_ir, 32'd0);
    check("reset_strobes", {27'd0, w_opnd, w_den, w_wen, w_retire, w_ill}, 32'd0);
    check("reset_dmem_rd_wr", {31'd0, w_drw}, 32'd1);
    check("reset_counters", w_cyc | w_ins, 32'd0);
    rst_a = 1'b0;

    // SKIP_MEM=1 sequence
    run(32'h2402_0005, 0, 0, 0, 0, mk(4, 1, 5'd2, 2'd0, 0, 0, 0, 2'd1, 32'h104));
    run(32'h2403_0007, 0, 0, 0, 0, mk(4, 1, 5'd3, 2'd0, 0, 0, 0, 2'd1, 32'h108));
    run(32'h0043_2021, 5, 7, 0, 0, mk(4, 1, 5'd4, 2'd0, 0, 0, 0, 2'd1, 32'h10C));
`ifdef MIPS_MC_PERF_EN
    check("instr_count", w_ins, 32'd3);
    check("cycle_count", w_cyc, 32'd12);
`else
    check("instr_count", w_ins, 32'd0);
    check("cycle_count", w_cyc, 32'd0);
`endif
    run(32'h0800_0080, 0, 0, 0, 0, mk(3, 0, 5'd0, 2'd0, 0, 0, 0, 2'd1, 32'h200));
    run(32'h1022_FFFE, 7, 7, 0, 0, mk(3, 0, 5'd0, 2'd0, 0, 0, 0, 2'd1, 32'h1FC));
    run(32'h1422_FFFE, 7, 7, 0, 0, mk(3, 0, 5'd0, 2'd0, 0, 0, 0, 2'd1, 32'h200));
    run(32'h1022_FFFE, 7, 8, 0, 0, mk(3, 0, 5'd0, 2'd0, 0, 0, 0, 2'd1, 32'h204));
    run(32'h8C25_0000, 0, 0, 0, 2, mk(7, 1, 5'd5, 2'd1, 3, 0, 0, 2'd1, 32'h208));
    run(32'hA025_0000, 0, 0, 0, 0, mk(4, 0, 5'd0, 2'd0, 1, 1, 0, 2'd0, 32'h20C));
    run(32'hAC25_0004, 0, 0, 0, 0, mk(4, 0, 5'd0, 2'd0, 1, 1, 0, 2'd1, 32'h210));
    run(32'h9026_0000, 0, 0, 0, 0, mk(5, 1, 5'd6, 2'd1, 1, 0, 0, 2'd0, 32'h214));
    run(32'h2827_000A, 0, 0, 2, 0, mk(6, 1, 5'd7, 2'd0, 0, 0, 0, 2'd1, 32'h218));
    run(32'h7022_4002, 0, 0, 0, 0, mk(4, 1, 5'd8, 2'd0, 0, 0, 0, 2'd1, 32'h21C));
    run(32'h00A0_0008, 32'h0040_0010, 0, 0, 0,
        mk(3, 0, 5'd0, 2'd0, 0, 0, 0, 2'd1, 32'h0040_0010));
    run(32'h0C00_0010, 0, 0, 0, 0, mk(4, 1, 5'd31, 2'd2, 0, 0, 0, 2'd1, 32'h40));
    run(32'hFC00_0000, 0, 0, 0, 0, mk(3, 0, 5'd0, 2'd0, 0, 0, 1, 2'd1, 32'h44));
    run(32'h00A0_0008, 32'hFFFF_FFFC, 0, 0, 0,
        mk(3, 0, 5'd0, 2'd0, 0, 0, 0, 2'd1, 32'hFFFF_FFFC));
    run(32'h2402_0005, 0, 0, 0, 0, mk(4, 1, 5'd2, 2'd0, 0, 0, 0, 2'd1, 32'h0));

    // Abort an ADDIU in WB: no write, no retire, everything back to reset values.
    t_imem = 32'h2409_0001;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check("abort_in_wb_state", {29'd0, w_state}, 32'd4);
    rst_a = 1'b1;
    @(negedge clk);
    check("abort_reg_wr_en", {31'd0, w_wen}, 32'd0);
    check("abort_retire", {31'd0, w_retire}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_pc", w_pc, 32'h100);
    check("abort_state", {29'd0, w_state}, 32'd0);
    check("abort_counters", w_cyc | w_ins, 32'd0);

    // SKIP_MEM=0 sequence
    sel = 1'b1;
    @(posedge clk);
    #1;
    check("b_reset_pc", w_pc, 32'h0);
    rst_b = 1'b0;
    run(32'h2402_0005, 0, 0, 0, 0, mk(5, 1, 5'd2, 2'd0, 0, 0, 0, 2'd1, 32'h4));
    run(32'h1422_0003, 1, 2, 0, 0, mk(5, 0, 5'd0, 2'd0, 0, 0, 0, 2'd1, 32'h14));
    run(32'h00A0_0008, 32'h300, 0, 0, 0, mk(5, 0, 5'd0, 2'd0, 0, 0, 0, 2'd1, 32'h300));
    run(32'hFC00_0000, 0, 0, 0, 0, mk(5, 0, 5'd0, 2'd0, 0, 0, 1, 2'd1, 32'h304));
    run(32'hAC25_0004, 0, 0, 0, 0, mk(5, 0, 5'd0, 2'd0, 1, 1, 0, 2'd1, 32'h308));
    run(32'h8C25_0000, 0, 0, 0, 1, mk(6, 1, 5'd5, 2'd1, 2, 0, 0, 2'd1, 32'h30C));

    repeat (2) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_mc_control.md
# mips_mc_control

Parametrised multi-cycle sequencer for the single-issue MIPS core: owns the PC and the instruction register, steps each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives every datapath strobe (operand latch, data-memory request, register-file write, next-PC select). Unlike the fixed 5-count controller, it stalls on memory `busy`, optionally skips unused states per instruction class (variable CPI), and generalises JR to any `rs`. It sits between the `pc`/`memory` instances and `regfile`/`alu` in the top-level `mips`.

## Interface
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.
- `SKIP_MEM`, 1, 1 = variable-CPI mode (states skipped per class); 0 = every instruction visits all five states.
- `clk`  in  1  clock; reset reset, synchronous, active-high; clock clk.
- `reset`  in  1  synchronous, active-high reset.
- `imem_rdata`  in  32  instruction memory read data.
- `imem_busy`  in  1  instruction memory not ready.
- `dmem_busy`  in  1  data memory not ready.
- `rs_data`  in  32  regfile read port 0 (`rs`), combinational.
- `rt_data`  in  32  regfile read port 1 (`rt`), combinational.
- `pc`  out  32  current PC, instruction fetch address.
- `ir`  out  32  latched instruction.
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- `opnd_en`  out  1  latch ALU operands A/B this cycle.
- `dmem_en`  out  1  data memory request.
- `dmem_rd_wr`  out  1  1 = read, 0 = write.
- `dmem_size`  out  2  2'b00 = byte (LBU/SB), 2'b01 = word.
- `reg_wr_en`  out  1  regfile write strobe.
- `reg_wr_num`  out  5  destination register.
- `wb_sel`  out  2  0 = ALU, 1 = memory, 2 = link (`pc`+4).
- `retire`  out  1  one-cycle pulse on the last cycle of each instruction.
- `illegal`  out  1  one-cycle pulse in EXEC for an unsupported opcode.
- `cycle_count`, `instr_count`  out  32 each  performance counters (see Configuration).

## Operation
- Supported opcodes: R-type 000000 (JR when `func`=001000), J 000010, JAL 000011, BEQ 000100, BNE 000101, ADDIU 001001, SLTI 001010, MUL 011100, LW 100011, LBU 100100, SW 101011, SB 101000. Any other opcode pulses `illegal` and executes as a NOP: no writes, PC+4.
- FETCH: hold while `imem_busy`. On the first cycle with `imem_busy`=0, latch `ir` <= `imem_rdata` and go to DECODE.
- DECODE: assert `opnd_en`, then go to EXEC.
- EXEC: resolve the next PC.
  - BEQ/BNE taken: `pc`+4+(sext(imm)<<2). Not taken: `pc`+4.
  - J/JAL: {`pc`[31:28], `ir`[25:0], 2'b00}.
  - JR: `rs_data` for any `rs`.
  - All others: `pc`+4.
- Next state with SKIP_MEM=1:
  - Branch, J, JR, illegal: FETCH.
  - Load/store: MEM.
  - ALU ops and JAL: WB.
- Next state with SKIP_MEM=0: always MEM, then always WB.
- MEM: for load/store, assert `dmem_en` and hold `dmem_rd_wr` (0 for SW/SB) until `dmem_busy`=0. A store then goes to FETCH (SKIP_MEM=1) or WB with no write. Non-memory instructions spend exactly one MEM cycle with `dmem_en`=0.
- WB: assert `reg_wr_en` for writers only: ALU ops, ADDIU, SLTI, MUL, LW, LBU, JAL.
  - `reg_wr_num`: 31 for JAL; `rt` for ADDIU/SLTI/LW/LBU; `rd` for R-type/MUL.
  - `wb_sel`: 1 for loads, 2 for JAL, 0 otherwise.
- The PC register updates only on the transition back to FETCH, together with `retire`.

## Timing
- Reset state:
  - `state`=FETCH, `pc`=PC_INIT, `ir`=0.
  - All strobes (`opnd_en`, `dmem_en`, `reg_wr_en`, `retire`, `illegal`) are 0, `dmem_rd_wr`=1, counters=0.
- Strobes decode combinationally from `state`/`ir` and are gated by `reset`. Reset asserted mid-instruction therefore produces no regfile or memory write in that cycle and aborts the instruction.
- Zero-wait CPI with SKIP_MEM=1:
  - Branch, J, JR: 3.
  - ALU ops, JAL, SW, SB: 4.
  - LW, LBU: 5.
- Zero-wait CPI with SKIP_MEM=0: 5 for every instruction.
- Each busy cycle in FETCH or MEM adds exactly one cycle.
- PC arithmetic is mod 2^32: a wrap from 0xFFFF_FFFC to 0 is legal.

## Configuration
- `MIPS_MC_PERF_EN` defined:
  - `cycle_count` increments every non-reset cycle.
  - `instr_count` increments on `retire`.
  - Both are 32-bit and wrap to 0.
- `MIPS_MC_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are generated.

## Test plan
- Reset with PC_INIT=32'h0000_0100, then release -> `pc`=0x100, `state`=0. ADDIU r2,r0,5 retires after 4 cycles with `reg_wr_num`=2, `wb_sel`=0, `pc`=0x104.
- BEQ at 0x200 with `rs_data`=`rt_data`=7, imm=0xFFFE -> `retire` at cycle 3, `pc`=0x1FC. Same with `rt_data`=8 -> `pc`=0x204.
- LW with `dmem_busy` high for 2 MEM cycles -> `dmem_en`=1 and `dmem_rd_wr`=1 for 3 cycles, `reg_wr_en` with `wb_sel`=1, `retire` at cycle 7.
- SB -> `dmem_size`=00, `dmem_rd_wr`=0 for exactly 1 cycle, `reg_wr_en` never high. JAL at 0x0040_0010 to index 0x10 -> `reg_wr_num`=31, `wb_sel`=2, `pc`=0x0000_0040.
- SKIP_MEM=0 with the sequence ADDIU, BNE, JR r5 (`rs_data`=0x300) -> each takes 5 cycles, final `pc`=0x300. Opcode 0x3F -> `illegal` pulse, no writes, `pc`+4.
- `MIPS_MC_PERF_EN` defined with 3 ALU instructions at SKIP_MEM=1 -> `instr_count`=3, `cycle_count`=12. Reset asserted in WB -> no `reg_wr_en` and both counters return to 0.
